// File: rtl/sequenciador_nivel.sv
// sequenciador_nivel: tank-level sequencer for the bar display.
// Steps a 3-bit level 0..7 at one step per DIV_PASSO cycles while a fill
// (encher) or drain (esvaziar) request is held, and blinks frequenciapiscar
// while a change is in progress.
// Optional blink generator: define SEQUENCIADOR_PISCA_EN to build it;
// otherwise frequenciapiscar is tied low and all other behaviour is unchanged.
module sequenciador_nivel #(
   parameter int DIV_PASSO = 50_000_000,
   parameter int DIV_PISCA = 12_500_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       encher,
   input  logic       esvaziar,
   output logic [3:0] q,
   output logic       frequenciapiscar,
   output logic       cheio,
   output logic       vazio,
   output logic [1:0] estado
);

   localparam int PW = $clog2(DIV_PASSO);

   localparam logic [1:0] OCIOSO     = 2'b00;
   localparam logic [1:0] ENCHENDO   = 2'b01;
   localparam logic [1:0] ESVAZIANDO = 2'b10;

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [2:0]    level;
   logic [PW-1:0] step_cnt;
   logic          fill_ok;
   logic          drain_ok;
   logic          step_end;
   logic          do_step;

   // Level arithmetic never wraps; the FSM leaves before the ends anyway.
   function automatic logic [2:0] sat_inc(input logic [2:0] v);
      return (v == 3'd7) ? 3'd7 : v + 3'd1;
   endfunction

   function automatic logic [2:0] sat_dec(input logic [2:0] v);
      return (v == 3'd0) ? 3'd0 : v - 3'd1;
   endfunction

   // A request is only valid while the opposite request is low.
   assign fill_ok  = encher & ~esvaziar;
   assign drain_ok = esvaziar & ~encher;
   assign step_end = (step_cnt == PW'(DIV_PASSO - 1));

   // Next-state decode; an invalid request on the terminal count exits without stepping.
   always_comb begin
      state_nxt = state;
      do_step   = 1'b0;
      case (state)
         OCIOSO: begin
            if (fill_ok && (level != 3'd7))
               state_nxt = ENCHENDO;
            else if (drain_ok && (level != 3'd0))
               state_nxt = ESVAZIANDO;
         end
         ENCHENDO: begin
            if (!fill_ok)
               state_nxt = OCIOSO;
            else if (step_end) begin
               do_step = 1'b1;
               if (level == 3'd6)
                  state_nxt = OCIOSO;
            end
         end
         ESVAZIANDO: begin
            if (!drain_ok)
               state_nxt = OCIOSO;
            else if (step_end) begin
               do_step = 1'b1;
               if (level == 3'd1)
                  state_nxt = OCIOSO;
            end
         end
         default: state_nxt = OCIOSO;
      endcase
   end

   // State, step counter and level registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= OCIOSO;
         step_cnt <= '0;
         level    <= 3'd0;
      end else begin
         state <= state_nxt;
         if ((state == OCIOSO) || (state_nxt == OCIOSO) || do_step)
            step_cnt <= '0;
         else
            step_cnt <= step_cnt + 1'b1;
         if (do_step)
            level <= (state == ENCHENDO) ? sat_inc(level) : sat_dec(level);
      end
   end

`ifdef SEQUENCIADOR_PISCA_EN
   localparam int BW = (DIV_PISCA > 1) ? $clog2(DIV_PISCA) : 1;

   logic [BW-1:0] blink_cnt;
   logic          blink;

   // Blink counter runs only while staying in an active state; leaving forces the strobe low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt <= '0;
         blink     <= 1'b0;
      end else if ((state == OCIOSO) || (state_nxt == OCIOSO)) begin
         blink_cnt <= '0;
         blink     <= 1'b0;
      end else if (blink_cnt == BW'(DIV_PISCA - 1)) begin
         blink_cnt <= '0;
         blink     <= ~blink;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   assign frequenciapiscar = blink;
`else
   assign frequenciapiscar = 1'b0;
`endif

   assign q      = {1'b0, level};
   assign cheio  = (level == 3'd7);
   assign vazio  = (level == 3'd0);
   assign estado = state;

endmodule

// File: tb/tb_sequenciador_nivel.sv
// Directed bench for sequenciador_nivel with DIV_PASSO=4, DIV_PISCA=2.
module tb_sequenciador_nivel;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       encher = 1'b0;
   logic       esvaziar = 1'b0;
   logic [3:0] q;
   logic       frequenciapiscar;
   logic       cheio;
   logic       vazio;
   logic [1:0] estado;

   int n_vec = 0;
   int n_err = 0;

`ifdef SEQUENCIADOR_PISCA_EN
   localparam bit PISCA_ON = 1'b1;
`else
   localparam bit PISCA_ON = 1'b0;
`endif

   sequenciador_nivel #(.DIV_PASSO(4), .DIV_PISCA(2)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .encher           (encher),
      .esvaziar         (esvaziar),
      .q                (q),
      .frequenciapiscar (frequenciapiscar),
      .cheio            (cheio),
      .vazio            (vazio),
      .estado           (estado)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_q;
      int exp_st;
      int exp_fp;

      // asynchronous reset before any clock edge
      #2 rst_n = 1'b0;
      #1;
      chk("rst_q", q, 0);
      chk("rst_st", estado, 0);
      chk("rst_vazio", vazio, 1);
      chk("rst_cheio", cheio, 0);
      chk("rst_fp", frequenciapiscar, 0);
      tick();
      tick();
      rst_n = 1'b1;

      // reset asserted mid-fill at level 3
      encher = 1'b1;
      tick();
      for (int i = 1; i <= 13; i++) tick();
      chk("pre_rst_q", q, 3);
      chk("pre_rst_st", estado, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_q", q, 0);
      chk("mid_rst_st", estado, 0);
      chk("mid_rst_vazio", vazio, 1);
      chk("mid_rst_fp", frequenciapiscar, 0);
      encher = 1'b0;
      #1 rst_n = 1'b1;
      tick();
      chk("post_rst_st", estado, 0);

      // full fill 0 -> 7, every edge checked
      encher = 1'b1;
      tick();
      chk("fill_e0_st", estado, 1);
      chk("fill_e0_q", q, 0);
      chk("fill_e0_fp", frequenciapiscar, 0);
      for (int n = 1; n <= 28; n++) begin
         tick();
         exp_q  = n / 4;
         exp_st = (n < 28) ? 1 : 0;
         exp_fp = (PISCA_ON && n < 28) ? ((n / 2) % 2) : 0;
         chk($sformatf("fill_e%0d_q", n), q, exp_q);
         chk($sformatf("fill_e%0d_st", n), estado, exp_st);
         chk($sformatf("fill_e%0d_fp", n), frequenciapiscar, exp_fp);
      end
      chk("fill_cheio", cheio, 1);
      chk("fill_vazio", vazio, 0);
      tick();
      chk("rej7_st", estado, 0);
      chk("rej7_q", q, 7);
      encher = 1'b0;

      // drain 7 -> 5 then release
      esvaziar = 1'b1;
      tick();
      chk("d75_e0_st", estado, 2);
      for (int i = 1; i <= 8; i++) tick();
      chk("d75_q", q, 5);
      esvaziar = 1'b0;
      tick();
      chk("d75_rel_st", estado, 0);
      chk("d75_rel_q", q, 5);
      chk("d75_rel_fp", frequenciapiscar, 0);

      // drain from 5 with early release after edge 10
      esvaziar = 1'b1;
      tick();
      chk("drn_e0_st", estado, 2);
      for (int n = 1; n <= 10; n++) begin
         tick();
         exp_q = (n < 4) ? 5 : ((n < 8) ? 4 : 3);
         chk($sformatf("drn_e%0d_q", n), q, exp_q);
         chk($sformatf("drn_e%0d_st", n), estado, 2);
      end
      esvaziar = 1'b0;
      tick();
      chk("drn_e11_st", estado, 0);
      chk("drn_e11_q", q, 3);
      chk("drn_e11_fp", frequenciapiscar, 0);
      tick();
      tick();
      chk("drn_hold_q", q, 3);

      // bring level to 2
      esvaziar = 1'b1;
      tick();
      for (int i = 1; i <= 4; i++) tick();
      chk("d32_q", q, 2);
      esvaziar = 1'b0;
      tick();
      chk("d32_st", estado, 0);

      // conflict during fill at level 2
      encher = 1'b1;
      tick();
      chk("cf_e0_st", estado, 1);
      tick();
      tick();
      esvaziar = 1'b1;
      tick();
      chk("cf_st", estado, 0);
      chk("cf_q", q, 2);
      chk("cf_fp", frequenciapiscar, 0);
      esvaziar = 1'b0;
      tick();
      chk("cf_re_st", estado, 1);
      for (int i = 1; i <= 3; i++) tick();
      chk("cf_re_e3_q", q, 2);
      tick();
      chk("cf_re_e4_q", q, 3);
      encher = 1'b0;
      tick();
      chk("cf_rel_st", estado, 0);

      // both requests high while idle
      encher = 1'b1;
      esvaziar = 1'b1;
      tick();
      chk("both_st1", estado, 0);
      tick();
      chk("both_st2", estado, 0);
      chk("both_q", q, 3);
      encher = 1'b0;
      esvaziar = 1'b0;

      // drain 3 -> 0, then drain request rejected at 0
      esvaziar = 1'b1;
      tick();
      for (int i = 1; i <= 12; i++) tick();
      chk("d30_q", q, 0);
      chk("d30_st", estado, 0);
      chk("d30_vazio", vazio, 1);
      tick();
      chk("rej0_st", estado, 0);
      chk("rej0_vazio", vazio, 1);
      esvaziar = 1'b0;

      // request dropped on the terminal count: exit, no step
      encher = 1'b1;
      tick();
      for (int i = 1; i <= 3; i++) tick();
      chk("ew_pre_st", estado, 1);
      encher = 1'b0;
      tick();
      chk("ew_st", estado, 0);
      chk("ew_q", q, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
